// File: rtl/message_ram_controller.sv
// LDPC message RAM: channel-LLR fill, address-driven reads, in-order write-back.
// Latency: read data registered 1 cycle after acceptance; write-back commits on the wb_valid edge.
// Backpressure: addr_ready drops in LOAD, while load_en is high, or once PEND_DEPTH reads await write-back.
module message_ram_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int PEND_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_done,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  addr_valid,
    output logic                  addr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  wb_valid,
    output logic                  wb_error,
    output logic                  busy
);

    localparam int PW    = $clog2(PEND_DEPTH);
    localparam int CW    = PW + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [CW-1:0] FULL = CW'(PEND_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   load_cnt_q, load_cnt_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    load_done_q, load_done_d;
    logic                    wb_error_q, wb_error_d;
    logic                    busy_q, busy_d;

    logic [DATA_WIDTH-1:0]   mem    [DEPTH];
    logic [ADDR_WIDTH-1:0]   pend_q [PEND_DEPTH];

    logic                    rd_acc;
    logic                    load_wr;
    logic                    wb_pop;
    logic [ADDR_WIDTH-1:0]   wb_addr;

    assign addr_ready = (state_q != S_LOAD) && !load_en && (count_q != FULL);
    assign rd_acc     = addr_valid && addr_ready;
    // The first load_en seen in IDLE already writes word 0; RUN never loads.
    assign load_wr    = load_en && (state_q != S_RUN);
    assign wb_pop     = wb_valid && (state_q != S_LOAD) && (count_q != '0);
    assign wb_addr    = pend_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CW'(rd_acc) - CW'(wb_pop);
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_acc;
        load_done_d = 1'b0;
        wb_error_d  = wb_error_q || (wb_valid && !wb_pop);

        if (rd_acc) begin
            wr_ptr_d  = wr_ptr_q + PW'(1);
            rd_data_d = (wb_pop && (wb_addr == addr)) ? wb_data : mem[addr];
        end
        if (wb_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case (state_q)
            S_IDLE, S_LOAD: begin
                if (load_wr) begin
                    if (load_cnt_q == '1) begin
                        state_d     = S_IDLE;
                        load_cnt_d  = '0;
                        load_done_d = 1'b1;
                    end else begin
                        state_d    = S_LOAD;
                        load_cnt_d = load_cnt_q + ADDR_WIDTH'(1);
                    end
                end else if ((state_q == S_IDLE) && rd_acc) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!rd_acc && (count_d == '0)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            load_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            load_done_q <= 1'b0;
            wb_error_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            load_done_q <= load_done_d;
            wb_error_q  <= wb_error_d;
            busy_q      <= busy_d;
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (load_wr) begin
            mem[load_cnt_q] <= load_data;
        end else if (wb_pop) begin
            mem[wb_addr] <= wb_data;
        end
        if (rd_acc) begin
            pend_q[wr_ptr_q] <= addr;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign load_done = load_done_q;
    assign wb_error  = wb_error_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_message_ram_controller.sv
// Directed bench for message_ram_controller with an 8-word RAM and 8-entry pending queue.
module tb_message_ram_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_en;
    logic [7:0] load_data;
    logic       load_done;
    logic [2:0] addr;
    logic       addr_valid;
    logic       addr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [7:0] wb_data;
    logic       wb_valid;
    logic       wb_error;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] m [8];
    logic [2:0] drain_q [8];

    message_ram_controller #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(3),
        .PEND_DEPTH(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_en    (load_en),
        .load_data  (load_data),
        .load_done  (load_done),
        .addr       (addr),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wb_data    (wb_data),
        .wb_valid   (wb_valid),
        .wb_error   (wb_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic av, input logic [2:0] a, input logic wv, input logic [7:0] wd);
        addr_valid = av;
        addr       = a;
        wb_valid   = wv;
        wb_data    = wd;
    endtask

    // One accepted read, then check registered data against the model.
    task automatic do_read(input string tag, input logic [2:0] a);
        drive(1'b1, a, 1'b0, 8'h00);
        step();
        chk({tag, "_vld"}, rd_valid, 1'b1);
        chk({tag, "_dat"}, rd_data, m[a]);
        drive(1'b0, 3'd0, 1'b0, 8'h00);
    endtask

    task automatic do_wb(input logic [2:0] a, input logic [7:0] d);
        drive(1'b0, 3'd0, 1'b1, d);
        m[a] = d;
        step();
        drive(1'b0, 3'd0, 1'b0, 8'h00);
    endtask

    initial begin
        reset = 1'b0;
        load_en = 1'b0;
        load_data = 8'h00;
        drive(1'b0, 3'd0, 1'b0, 8'h00);
        @(negedge clk);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_load_done", load_done, 1'b0);
        chk("rst_wb_error", wb_error, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", addr_ready, 1'b1);
        load_en = 1'b1;
        #1 chk("rst_ready_load_en", addr_ready, 1'b0);
        load_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            load_en   = 1'b1;
            load_data = 8'h10 + 8'(i);
            m[i]      = 8'h10 + 8'(i);
            step();
            if (i == 3) chk("load_busy", busy, 1'b1);
            if (i == 4) begin
                addr_valid = 1'b1;
                #1 chk("load_blocks_rd", addr_ready, 1'b0);
                addr_valid = 1'b0;
            end
            if (i == 6) chk("load_done_early", load_done, 1'b0);
        end
        chk("load_done_pulse", load_done, 1'b1);
        chk("load_busy_end", busy, 1'b0);
        load_en = 1'b0;
        step();
        chk("load_done_clear", load_done, 1'b0);

        for (int i = 0; i < 8; i++) begin
            do_read($sformatf("rd%0d", i), 3'(i));
        end
        #1 chk("full_ready", addr_ready, 1'b0);
        chk("full_busy", busy, 1'b1);

        drive(1'b1, 3'd3, 1'b1, m[0]);
        #1 chk("full_ready_wb", addr_ready, 1'b0);
        step();
        chk("full_no_rd", rd_valid, 1'b0);
        drive(1'b1, 3'd3, 1'b0, 8'h00);
        #1 chk("bp_ready_back", addr_ready, 1'b1);
        step();
        chk("bp_rd_vld", rd_valid, 1'b1);
        chk("bp_rd_dat", rd_data, m[3]);
        drive(1'b0, 3'd0, 1'b0, 8'h00);
        #1 chk("bp_full_again", addr_ready, 1'b0);
        drain_q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3};
        for (int i = 0; i < 8; i++) do_wb(drain_q[i], m[drain_q[i]]);
        chk("drain_busy", busy, 1'b0);
        chk("drain_err", wb_error, 1'b0);

        do_read("rt_rd3", 3'd3);
        do_read("rt_rd5", 3'd5);
        do_wb(3'd3, 8'hA3);
        do_wb(3'd5, 8'hA5);
        do_read("rt_rerd3", 3'd3);
        do_read("rt_rerd5", 3'd5);
        do_wb(3'd3, 8'hA3);
        do_wb(3'd5, 8'hA5);
        chk("rt_err", wb_error, 1'b0);
        chk("rt_idle", busy, 1'b0);

        do_read("byp_rd2", 3'd2);
        drive(1'b1, 3'd2, 1'b1, 8'h5C);
        step();
        chk("byp_vld", rd_valid, 1'b1);
        chk("byp_dat", rd_data, 8'h5C);
        m[2] = 8'h5C;
        do_wb(3'd2, 8'h5D);
        do_read("byp_rerd2", 3'd2);
        do_wb(3'd2, 8'h5D);
        chk("byp_err", wb_error, 1'b0);

        drive(1'b0, 3'd0, 1'b1, 8'hEE);
        step();
        drive(1'b0, 3'd0, 1'b0, 8'h00);
        chk("err_set", wb_error, 1'b1);
        do_read("err_ram0", 3'd0);
        do_read("err_ram4", 3'd4);
        do_wb(3'd0, m[0]);
        do_wb(3'd4, m[4]);
        step();
        chk("err_sticky", wb_error, 1'b1);

        for (int i = 4; i < 8; i++) do_read($sformatf("pre_rst%0d", i), 3'(i));
        reset = 1'b0;
        #1;
        chk("mid_rst_rd_data", rd_data, 8'h00);
        chk("mid_rst_rd_valid", rd_valid, 1'b0);
        chk("mid_rst_load_done", load_done, 1'b0);
        chk("mid_rst_wb_error", wb_error, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", addr_ready, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 3'd0, 1'b1, 8'h77);
        step();
        drive(1'b0, 3'd0, 1'b0, 8'h00);
        chk("post_rst_err", wb_error, 1'b1);
        do_read("post_rst_rd6", 3'd6);
        do_read("post_rst_rd1", 3'd1);
        do_wb(3'd6, m[6]);
        do_wb(3'd1, m[1]);
        chk("post_rst_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/message_ram_controller.md
# message_ram_controller

Owns the LDPC message RAM and sits directly downstream of the address generator. It uses the generator's address stream to read stored messages for the node processor, then writes the processor's updated messages back to the same addresses in order. It also handles the initial channel-LLR fill of the RAM. Back-pressure `addr_ready` drives the address generator's `en`.

## Interface
- DATA_WIDTH, 8, message/LLR word width
- ADDR_WIDTH, 8, RAM address width; depth = 2**ADDR_WIDTH
- PEND_DEPTH, 8, maximum reads awaiting write-back (power of 2, ≥2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- load_en  in  1  load-data valid (channel-LLR fill)
- load_data  in  DATA_WIDTH  LLR to store
- load_done  out  1  one-cycle pulse after last load write
- addr  in  ADDR_WIDTH  read address from address generator `out`
- addr_valid  in  1  `addr` valid this cycle
- addr_ready  out  1  read accepted when addr_valid & addr_ready; drives generator `en`
- rd_data  out  DATA_WIDTH  message read from RAM
- rd_valid  out  1  rd_data valid
- wb_data  in  DATA_WIDTH  updated message from node processor
- wb_valid  in  1  wb_data valid
- wb_error  out  1  sticky: write-back with no pending address
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, LOAD, RUN.
- IDLE -> LOAD on load_en; load_en has priority over addr_valid. IDLE -> RUN on an accepted read.
- LOAD: an internal load counter starts at 0. Each cycle load_en=1 writes load_data at the counter and increments it. load_en=0 stalls. A write at 2**ADDR_WIDTH-1 returns to IDLE, pulses load_done next cycle and clears the counter. Reads are blocked in LOAD.
- RUN -> IDLE when no read is accepted this cycle and the pending queue is empty after this cycle's pop.
- addr_ready = (state != LOAD) & !load_en & !queue_full. In RUN, load_en only blocks reads; once the queue drains the FSM goes IDLE, then LOAD.
- Accepted read: the RAM is read at addr and addr is pushed into a PEND_DEPTH-entry address FIFO.
- wb_valid with a non-empty queue: pop the head address and write wb_data there. Write-back order equals read order.
- wb_valid with an empty queue: drop the write and set wb_error (sticky until reset). wb_valid is ignored in LOAD and also sets wb_error there.
- Same-cycle push and pop: both take effect and the count is unchanged. Push while full cannot occur because addr_ready is low.
- Same-cycle read and write-back to the same address: write-first bypass, so rd_data returns wb_data.
- RAM contents are not reset. The load counter, FIFO pointers, count, FSM and outputs are reset.

## Timing
- Reset values: rd_data=0, rd_valid=0, load_done=0, wb_error=0, busy=0. While reset is low, the FSM is IDLE and the queue empty, so addr_ready = !load_en.
- Read latency 1: rd_valid/rd_data are registered the cycle after acceptance. rd_valid=0 on cycles with no accepted read.
- Write-back writes the RAM on the wb_valid edge. A read of that address on the following cycle sees the new data.
- addr_ready is combinational from state, count and load_en. It drops in the same cycle the queue becomes full, meaning count==PEND_DEPTH after the edge.
- load_done is asserted exactly one cycle, the cycle after the final load write edge. busy stays 1 during that final write cycle.
- Reset mid-operation clears the queue. Pending write-backs are lost; any subsequent wb_valid sets wb_error.

## Test plan
- Load, ADDR_WIDTH=3: drive load_data=0x10..0x17 with load_en=1 for 8 cycles. Expect load_done one pulse after the 8th write and busy back to 0. Then read addr 0..7 and expect rd_data 0x10..0x17, each 1 cycle after acceptance.
- Round trip: after the load, read 3,5; write back 0xA3 then 0xA5 with wb_valid. Re-reading 3 gives 0xA3 and 5 gives 0xA5; wb_error=0.
- Back-pressure, PEND_DEPTH=8: accept 8 reads with no write-back. addr_ready=0 with count 8. One wb_valid with addr_valid held restores addr_ready the next cycle; the queue count never exceeds 8.
- Bypass: with addr 2 at head, assert wb_valid wb_data=0x5C and read addr 2 in the same cycle. rd_data=0x5C next cycle.
- Error: wb_valid with an empty queue sets wb_error=1; the RAM is unchanged and wb_error holds until reset.
- Reset mid-RUN with 4 pending: reset drives all outputs to their reset values. After release, wb_valid sets wb_error, and RAM data loaded earlier is still readable.
